// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequencer between the CPU load/store stage and the byte-addressed RAM.
//   It accepts one request at a time and checks its size and alignment. It
//   then runs the RAM memFuncActive/memFuncComplete handshake, keeping the
//   address, size and direction stable. The response is the zero- or
//   sign-extended load result, or an error code.
//
// Ports
//   Clk, nReset        clock (rising edge), asynchronous active-low reset
//   reqValid/reqReady  request handshake; the requester holds reqValid and
//                      the request fields until an edge where both are high
//   reqWrite/reqSize/reqSigned/reqAddr/reqData  request fields
//   respValid          one-cycle response pulse
//   respData/respError/errCode  response fields, held until the next response
//   memFuncActive/readWrite/address/dataSize/memDataIn  to the RAM
//   memDataOut/memFuncComplete                          from the RAM
//   dbg_state          current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge with reqValid & reqReady.
// reqReady is high only in IDLE (and never during reset). respValid has no
// back-pressure; it is a single-cycle pulse.
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int TIMEOUT    = 15
) (
  input  logic                  Clk,
  input  logic                  nReset,
  input  logic                  reqValid,
  input  logic                  reqWrite,
  input  logic [1:0]            reqSize,
  input  logic                  reqSigned,
  input  logic [ADDR_WIDTH-1:0] reqAddr,
  input  logic [31:0]           reqData,
  output logic                  reqReady,
  output logic                  respValid,
  output logic [31:0]           respData,
  output logic                  respError,
  output logic [1:0]            errCode,
  output logic                  memFuncActive,
  output logic                  readWrite,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [1:0]            dataSize,
  output logic [31:0]           memDataIn,
  input  logic [31:0]           memDataOut,
  input  logic                  memFuncComplete,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACTIVE = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_SIZE  = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t state, next_state;

  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic [31:0]           data_q;
  logic                  signed_q;
  logic                  active_q;
  logic [7:0]            wait_cnt;
  logic                  resp_error_q;
  logic [1:0]            err_code_q;
  logic [31:0]           resp_data_q;

  logic       accept;
  logic [1:0] chk_err;
  logic       timed_out;
  logic [31:0] load_ext;

  assign accept = reqValid && (state == S_IDLE);

  // Size is checked before alignment, so an illegal size wins.
  always_comb begin
    chk_err = ERR_OK;
    if (reqSize == 2'b10)
      chk_err = ERR_SIZE;
    else if (reqSize == 2'b01 && reqAddr[0])
      chk_err = ERR_ALIGN;
    else if (reqSize == 2'b11 && reqAddr[1:0] != 2'b00)
      chk_err = ERR_ALIGN;
  end

  // The counter holds the number of WAIT edges already seen without
  // completion. The edge that would make it reach TIMEOUT aborts instead.
  assign timed_out = !memFuncComplete && (wait_cnt == TMO_LAST);

  always_comb begin
    load_ext = memDataOut;
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & memDataOut[7]}},  memDataOut[7:0]};
      2'b01:   load_ext = {{16{signed_q & memDataOut[15]}}, memDataOut[15:0]};
      default: load_ext = memDataOut;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) next_state = (chk_err != ERR_OK) ? S_RESP : S_SETUP;
      end
      S_SETUP:  next_state = S_ACTIVE;
      S_ACTIVE: next_state = S_WAIT;
      S_WAIT: begin
        if (memFuncComplete || timed_out) next_state = S_RESP;
      end
      S_RESP:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      rw_q         <= 1'b0;
      addr_q       <= '0;
      size_q       <= 2'b00;
      data_q       <= 32'h0;
      signed_q     <= 1'b0;
      active_q     <= 1'b0;
      wait_cnt     <= 8'h0;
      resp_error_q <= 1'b0;
      err_code_q   <= ERR_OK;
      resp_data_q  <= 32'h0;
    end else begin
      // memFuncActive is high exactly in ACTIVE and WAIT.
      active_q <= (next_state == S_ACTIVE) || (next_state == S_WAIT);

      if (accept) begin
        if (chk_err != ERR_OK) begin
          // A rejected request leaves the RAM-side outputs untouched.
          resp_error_q <= 1'b1;
          err_code_q   <= chk_err;
          resp_data_q  <= 32'h0;
        end else begin
          rw_q     <= reqWrite;
          addr_q   <= reqAddr;
          size_q   <= reqSize;
          data_q   <= reqData;
          signed_q <= reqSigned;
        end
      end

      if (state == S_ACTIVE)
        wait_cnt <= 8'h0;
      else if (state == S_WAIT && !memFuncComplete)
        wait_cnt <= wait_cnt + 8'h1;

      if (state == S_WAIT) begin
        if (memFuncComplete) begin
          resp_error_q <= 1'b0;
          err_code_q   <= ERR_OK;
          resp_data_q  <= rw_q ? 32'h0 : load_ext;
        end else if (timed_out) begin
          resp_error_q <= 1'b1;
          err_code_q   <= ERR_TMO;
          resp_data_q  <= 32'h0;
        end
      end
    end
  end

  assign reqReady      = (state == S_IDLE) && nReset;
  assign respValid     = (state == S_RESP);
  assign respData      = resp_data_q;
  assign respError     = resp_error_q;
  assign errCode       = err_code_q;
  assign memFuncActive = active_q;
  assign readWrite     = rw_q;
  assign address       = addr_q;
  assign dataSize      = size_q;
  assign memDataIn     = data_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl. A behavioural big-endian 512x8 RAM
// stub answers the handshake. It can complete at once, never complete, or
// hold memFuncComplete high all the time.
module tb_mem_access_ctrl;

  logic        Clk = 1'b0;
  logic        nReset;
  logic        reqValid;
  logic        reqWrite;
  logic [1:0]  reqSize;
  logic        reqSigned;
  logic [8:0]  reqAddr;
  logic [31:0] reqData;
  logic        reqReady;
  logic        respValid;
  logic [31:0] respData;
  logic        respError;
  logic [1:0]  errCode;
  logic        memFuncActive;
  logic        readWrite;
  logic [8:0]  address;
  logic [1:0]  dataSize;
  logic [31:0] memDataIn;
  logic [31:0] memDataOut;
  logic        memFuncComplete;
  logic [2:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  logic hold0 = 1'b0;
  logic hold1 = 1'b0;
  logic mem_init = 1'b0;
  logic [7:0] mem [512];

  mem_access_ctrl #(.ADDR_WIDTH(9), .TIMEOUT(15)) dut (
    .Clk(Clk), .nReset(nReset),
    .reqValid(reqValid), .reqWrite(reqWrite), .reqSize(reqSize),
    .reqSigned(reqSigned), .reqAddr(reqAddr), .reqData(reqData),
    .reqReady(reqReady), .respValid(respValid), .respData(respData),
    .respError(respError), .errCode(errCode),
    .memFuncActive(memFuncActive), .readWrite(readWrite), .address(address),
    .dataSize(dataSize), .memDataIn(memDataIn), .memDataOut(memDataOut),
    .memFuncComplete(memFuncComplete), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- RAM stub ----------------
  assign memFuncComplete = hold1 ? 1'b1 : (hold0 ? 1'b0 : memFuncActive);

  always_comb begin
    case (dataSize)
      2'b00:   memDataOut = {24'h0, mem[address]};
      2'b01:   memDataOut = {16'h0, mem[address], mem[address + 9'd1]};
      default: memDataOut = {mem[address], mem[address + 9'd1],
                             mem[address + 9'd2], mem[address + 9'd3]};
    endcase
  end

  always @(posedge Clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
      mem[9'h028] <= 8'h8C; mem[9'h029] <= 8'h07;
      mem[9'h02A] <= 8'h00; mem[9'h02B] <= 8'h28;
      mem[9'h040] <= 8'hF0;
      mem[9'h042] <= 8'h80; mem[9'h043] <= 8'h01;
      mem_init <= 1'b1;
    end else if (memFuncActive && readWrite && memFuncComplete) begin
      case (dataSize)
        2'b00: mem[address] <= memDataIn[7:0];
        2'b01: begin
          mem[address]        <= memDataIn[15:8];
          mem[address + 9'd1] <= memDataIn[7:0];
        end
        default: begin
          mem[address]        <= memDataIn[31:24];
          mem[address + 9'd1] <= memDataIn[23:16];
          mem[address + 9'd2] <= memDataIn[15:8];
          mem[address + 9'd3] <= memDataIn[7:0];
        end
      endcase
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one request and follows it to its response. It reports the
  // latency (negedges after the acceptance edge until respValid), the cycles
  // with memFuncActive high, and whether the RAM-side outputs were stable
  // from SETUP to RESP. It also checks the pulse shape and that the
  // response is held.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [8:0] a, input logic [31:0] d,
                         output int lat, output int act_cyc, output logic stable);
    logic got;
    logic [31:0] held;
    got = 1'b0; lat = 0; act_cyc = 0; stable = 1'b1; held = 32'h0;
    @(negedge Clk);
    for (int i = 0; i < 20 && !reqReady; i++) @(negedge Clk);
    reqValid = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg;
    reqAddr = a; reqData = d;
    @(posedge Clk);
    #1 reqValid = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge Clk);
      if (memFuncActive) act_cyc++;
      if (dbg_state != 3'd0 && (readWrite !== w || address !== a || memDataIn !== d))
        stable = 1'b0;
      if (respValid) begin
        got = 1'b1;
        lat = c;
        held = respData;
        chk("ready_low_in_resp", {31'h0, reqReady}, 32'h0);
        chk("active_low_in_resp", {31'h0, memFuncActive}, 32'h0);
      end
    end
    chk("resp_seen", {31'h0, got}, 32'h1);
    @(negedge Clk);
    chk("resp_pulse_one_cycle", {31'h0, respValid}, 32'h0);
    chk("ready_after_resp", {31'h0, reqReady}, 32'h1);
    chk("resp_data_held", respData, held);
  endtask

  // ---------------- directed sequence ----------------
  int   lat, act;
  logic stable;

  initial begin
    nReset = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00;
    reqSigned = 1'b0; reqAddr = 9'h0; reqData = 32'h0;

    // Reset state
    repeat (3) @(negedge Clk);
    chk("rst_ready", {31'h0, reqReady}, 32'h0);
    chk("rst_active", {31'h0, memFuncActive}, 32'h0);
    chk("rst_resp_valid", {31'h0, respValid}, 32'h0);
    chk("rst_resp_data", respData, 32'h0);
    chk("rst_err", {30'h0, errCode}, 32'h0);
    chk("rst_addr", {23'h0, address}, 32'h0);
    chk("rst_state", {29'h0, dbg_state}, 32'h0);
    nReset = 1'b1;
    @(negedge Clk);
    chk("ready_after_rst", {31'h0, reqReady}, 32'h1);

    // 1: load word 0x028
    run_req(1'b0, 2'b11, 1'b0, 9'h028, 32'h0, lat, act, stable);
    chk("lw_latency", lat, 4);
    chk("lw_data", respData, 32'h8C070028);
    chk("lw_err", {30'h0, errCode}, 32'h0);
    chk("lw_resp_error", {31'h0, respError}, 32'h0);
    chk("lw_active_cycles", act, 2);

    // 2: byte / halfword extension
    run_req(1'b0, 2'b00, 1'b1, 9'h040, 32'h0, lat, act, stable);
    chk("lb_signed", respData, 32'hFFFFFFF0);
    run_req(1'b0, 2'b00, 1'b0, 9'h040, 32'h0, lat, act, stable);
    chk("lb_unsigned", respData, 32'h000000F0);
    run_req(1'b0, 2'b01, 1'b1, 9'h042, 32'h0, lat, act, stable);
    chk("lh_signed", respData, 32'hFFFF8001);
    run_req(1'b0, 2'b01, 1'b0, 9'h042, 32'h0, lat, act, stable);
    chk("lh_unsigned", respData, 32'h00008001);

    // 3: store halfword 0x102
    run_req(1'b1, 2'b01, 1'b0, 9'h102, 32'h1234ABCD, lat, act, stable);
    chk("sh_mem_102", {24'h0, mem[9'h102]}, 32'h000000AB);
    chk("sh_mem_103", {24'h0, mem[9'h103]}, 32'h000000CD);
    chk("sh_stable", {31'h0, stable}, 32'h1);
    chk("sh_resp_data", respData, 32'h0);
    chk("sh_resp_error", {31'h0, respError}, 32'h0);
    run_req(1'b0, 2'b01, 1'b0, 9'h102, 32'h0, lat, act, stable);
    chk("sh_readback", respData, 32'h0000ABCD);

    // 4: misaligned and illegal size
    run_req(1'b0, 2'b11, 1'b0, 9'h101, 32'h0, lat, act, stable);
    chk("lw_mis_error", {31'h0, respError}, 32'h1);
    chk("lw_mis_code", {30'h0, errCode}, 32'h1);
    chk("lw_mis_no_active", act, 0);
    chk("lw_mis_latency", lat, 1);
    chk("lw_mis_data", respData, 32'h0);
    run_req(1'b0, 2'b01, 1'b0, 9'h041, 32'h0, lat, act, stable);
    chk("lh_mis_code", {30'h0, errCode}, 32'h1);
    run_req(1'b0, 2'b10, 1'b0, 9'h101, 32'h0, lat, act, stable);
    chk("size_prio_code", {30'h0, errCode}, 32'h2);
    chk("size_no_active", act, 0);

    // 5: timeout, then complete held high
    hold0 = 1'b1;
    run_req(1'b0, 2'b11, 1'b0, 9'h028, 32'h0, lat, act, stable);
    chk("tmo_error", {31'h0, respError}, 32'h1);
    chk("tmo_code", {30'h0, errCode}, 32'h3);
    chk("tmo_latency", lat, 18);
    chk("tmo_active_cycles", act, 16);
    hold0 = 1'b0;
    hold1 = 1'b1;
    run_req(1'b0, 2'b00, 1'b0, 9'h040, 32'h0, lat, act, stable);
    chk("stale_latency", lat, 4);
    chk("stale_active_cycles", act, 2);
    chk("stale_data", respData, 32'h000000F0);
    run_req(1'b0, 2'b11, 1'b0, 9'h028, 32'h0, lat, act, stable);
    chk("stale2_latency", lat, 4);
    chk("stale2_data", respData, 32'h8C070028);
    hold1 = 1'b0;

    // 6: reset during WAIT
    hold0 = 1'b1;
    @(negedge Clk);
    reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'b11; reqSigned = 1'b0;
    reqAddr = 9'h028; reqData = 32'h0;
    @(posedge Clk);
    #1 reqValid = 1'b0;
    for (int i = 0; i < 10 && dbg_state != 3'd3; i++) @(negedge Clk);
    chk("rstw_in_wait", {29'h0, dbg_state}, 32'h3);
    chk("rstw_active_before", {31'h0, memFuncActive}, 32'h1);
    #2 nReset = 1'b0;
    #1;
    chk("rstw_active_async", {31'h0, memFuncActive}, 32'h0);
    chk("rstw_ready_low", {31'h0, reqReady}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("rstw_no_resp", {31'h0, respValid}, 32'h0);
    end
    nReset = 1'b1;
    hold0 = 1'b0;
    @(negedge Clk);
    chk("rstw_ready_after", {31'h0, reqReady}, 32'h1);
    chk("rstw_no_resp_after", {31'h0, respValid}, 32'h0);
    run_req(1'b0, 2'b11, 1'b0, 9'h028, 32'h0, lat, act, stable);
    chk("rstw_next_latency", lat, 4);
    chk("rstw_next_data", respData, 32'h8C070028);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
